flop_share_arbiter: RTL and testbench

// Round-robin write arbiter that shares the single 8-bit flipflop register between NREQ requesters.
// - Sits between the requesters and the flipflop DUV: drives its qin input and reads back its qout.
// - Grants one requester at a time, launches the write, then checks readback and reports done/err.
// - qin is registered and changes only on a grant edge, so the flop holds its value between writes.

---
 rtl/flop_share_arbiter.sv | 89 ++++++++
 tb/tb_flop_share_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/flop_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit flop between NREQ requesters.
// Each grant drives qin, lets the flop capture it, then checks qout readback.
module flop_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       grant,
  output logic [NREQ-1:0]       done,
  output logic                  err,
  output logic                  busy,
  output logic [WIDTH-1:0]      qin,
  input  logic [WIDTH-1:0]      qout
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    own;
  logic [WIDTH-1:0] lat_data;

  logic [PW-1:0]    win;
  logic             found;
  logic [PW-1:0]    idx;
  int               j;

  // Scan ptr, ptr+1, ... with explicit wrap so NREQ need not be a power of 2.
  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      idx = PW'(j);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      grant    <= '0;
      done     <= '0;
      err      <= 1'b0;
      busy     <= 1'b0;
      qin      <= '0;
      ptr      <= '0;
      own      <= '0;
      lat_data <= '0;
    end else begin
      done <= '0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            grant    <= NREQ'(1) << win;
            qin      <= wdata[win*WIDTH +: WIDTH];
            lat_data <= wdata[win*WIDTH +: WIDTH];
            own      <= win;
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: state <= CHECK;
        CHECK: begin
          done  <= NREQ'(1) << own;
          err   <= (qout != lat_data);
          grant <= '0;
          busy  <= 1'b0;
          ptr   <= (own == PW'(NREQ-1)) ? '0 : own + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flop_share_arbiter.sv
// Directed bench for flop_share_arbiter with a behavioural flop on qin/qout.
module tb_flop_share_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       grant, done;
  logic                  err, busy;
  logic [WIDTH-1:0]      qin, qout;
  logic [WIDTH-1:0]      flop_q;
  logic                  force_bad = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  flop_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .req(req), .wdata(wdata),
    .grant(grant), .done(done), .err(err), .busy(busy),
    .qin(qin), .qout(qout)
  );

  always #5 clk = ~clk;

  // The shared flipflop: captures qin every edge, no reset.
  always @(posedge clk) flop_q <= qin;
  assign qout = force_bad ? '0 : flop_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full write: grant edge, capture edge, check edge. req is left as set.
  task automatic do_write(input string tag, input logic [NREQ-1:0] r,
                          input logic [NREQ-1:0] g, input logic [7:0] d,
                          input logic bad);
    req = r;
    step();
    chk({tag, ".grant"}, grant, g);
    chk({tag, ".qin"},   qin,   d);
    chk({tag, ".busy"},  busy,  1);
    chk({tag, ".done0"}, done,  0);
    step();
    chk({tag, ".qout"},  qout,  d);
    chk({tag, ".drvdone"}, done, 0);
    if (bad) force_bad = 1'b1;
    step();
    force_bad = 1'b0;
    chk({tag, ".done"},  done,  g);
    chk({tag, ".err"},   err,   bad);
    chk({tag, ".gidle"}, grant, 0);
    chk({tag, ".bidle"}, busy,  0);
  endtask

  initial begin
    reset = 1'b0;
    req   = '1;
    wdata = '0;
    #1;
    // 1: held in reset with all requests up
    for (int c = 0; c < 3; c++) begin
      step();
      chk("rst.grant", grant, 0);
      chk("rst.done",  done,  0);
      chk("rst.qin",   qin,   8'h00);
      chk("rst.busy",  busy,  0);
    end
    reset = 1'b1;
    req   = '0;
    step();
    chk("idle.grant", grant, 0);

    // 2: single write from requester 2
    wdata[2*8 +: 8] = 8'hA5;
    do_write("single", 4'b0100, 4'b0100, 8'hA5, 1'b0);
    req = '0;
    step();
    chk("single.doneclr", done, 0);
    chk("single.errclr",  err,  0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("hold.qout", qout, 8'hA5);
      chk("hold.qin",  qin,  8'hA5);
    end

    // 4: wrap from ptr=3 with requesters 3 and 0
    wdata[3*8 +: 8] = 8'h5A;
    wdata[0*8 +: 8] = 8'hC3;
    do_write("wrap3", 4'b1001, 4'b1000, 8'h5A, 1'b0);
    do_write("wrap0", 4'b1001, 4'b0001, 8'hC3, 1'b0);
    req = '0;
    step();
    // ptr now 1: requesters 0 and 2 -> 2 wins
    wdata[2*8 +: 8] = 8'h66;
    do_write("ptr1", 4'b0101, 4'b0100, 8'h66, 1'b0);
    req = '0;

    // 3: round robin from ptr=0 with all requesters
    reset = 1'b0;
    step();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) wdata[i*8 +: 8] = 8'h10 + 8'(i);
    for (int n = 0; n < 5; n++)
      do_write($sformatf("rr%0d", n), 4'b1111, 4'(1 << (n % 4)), 8'h10 + 8'(n % 4), 1'b0);
    req = '0;
    step();

    // 5: readback error (ptr=1 -> requester 1)
    wdata[1*8 +: 8] = 8'h3C;
    do_write("rberr", 4'b0010, 4'b0010, 8'h3C, 1'b1);
    req = '0;
    step();
    chk("rberr.errclr", err,  0);
    chk("rberr.idle",   busy, 0);

    // 6: reset while in CHECK aborts the write (ptr=2)
    wdata[2*8 +: 8] = 8'h77;
    req = 4'b0100;
    step();
    chk("abort.grant", grant, 4'b0100);
    step();
    reset = 1'b0;
    req   = '0;
    step();
    chk("abort.done",  done,  0);
    chk("abort.grant0", grant, 0);
    chk("abort.busy",  busy,  0);
    chk("abort.err",   err,   0);
    chk("abort.qin",   qin,   8'h00);
    reset = 1'b1;
    step();
    chk("abort.nodone", done, 0);
    wdata[1*8 +: 8] = 8'h9E;
    do_write("post", 4'b0010, 4'b0010, 8'h9E, 1'b0);
    req = '0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
